uart_rx: RTL and testbench

- Serial receive front end for the UART link on the TinyFPGA board. It sits directly downstream of the board-level rx pin and owns metastability cleanup.
- Samples 8N1 frames (optional even parity) at mid-bit using a clock-cycle bit timer. Presents each byte on a valid/ready holding register to the core.
- Flags framing, overrun and parity errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART types and constants (receiver states, frame width, rate).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS         = 8;
    // 16 MHz system clock at 115200 baud; shared with the transmitter.
    localparam int UART_CLKS_PER_BIT = 139;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
//------------------------------------------------------------------------------
// Module   : uart_sync
// Brief    : SYNC_STAGES flop chain for asynchronous pin inputs, resets to 1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Brief    : Mid-bit sampling UART receiver with valid/ready holding register.
//            Optional even parity enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int              c_TW       = $clog2(CLKS_PER_BIT + 1);
    localparam int              c_BW       = $clog2(DATA_BITS);
    localparam logic [c_TW-1:0] c_FULL     = c_TW'(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_HALF     = c_TW'(CLKS_PER_BIT / 2);
    localparam logic [c_TW-1:0] c_ONE      = c_TW'(1);
    localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);

    logic                 w_rs;
    logic                 w_expire;
    logic                 w_done;

    uart_state_e          r_state,     w_state_nxt;
    logic [c_TW-1:0]      r_timer,     w_timer_nxt;
    logic [c_BW-1:0]      r_bit,       w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,      w_data_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun,   w_overrun_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad,    w_par_bad_nxt;
    logic                 r_parity_err, w_parity_err_nxt;
`endif

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (w_rs)
    );

    assign w_expire = (r_timer == c_ONE);

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_bit_nxt       = r_bit;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid & ~ready;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;
        w_done          = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_parity_err_nxt = 1'b0;
`endif

        case (r_state)
            ST_IDLE: begin
                if (!w_rs) begin
                    w_timer_nxt = c_HALF;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (!w_expire) begin
                    w_timer_nxt = r_timer - c_ONE;
                end else if (w_rs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = c_FULL;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!w_expire) begin
                    w_timer_nxt = r_timer - c_ONE;
                end else begin
                    w_shift_nxt = {w_rs, r_shift[DATA_BITS-1:1]};
                    w_timer_nxt = c_FULL;
                    w_bit_nxt   = r_bit + c_BW'(1);
                    if (r_bit == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!w_expire) begin
                    w_timer_nxt = r_timer - c_ONE;
                end else begin
                    // Even parity: line bit must equal XOR of the data bits.
                    w_par_bad_nxt = w_rs ^ (^r_shift);
                    w_timer_nxt   = c_FULL;
                    w_state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (!w_expire) begin
                    w_timer_nxt = r_timer - c_ONE;
                end else if (w_rs) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_frame_err_nxt = 1'b1;
                    w_state_nxt     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Held-low line: one frame_err only, rearm once the line idles.
                if (w_rs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_done) begin
            if (!r_valid || ready) begin
                w_data_nxt  = r_shift;
                w_valid_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            w_parity_err_nxt = r_par_bad;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SS  = 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    // rx edge to valid: synchronizer, half bit to start centre, NB-1 bits, register.
    localparam int LAT = SS + CPB / 2 + (NB - 1) * CPB + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   t0 = 0;
    int   rise_cyc = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;
    int   pe_cnt = 0;
    int   pe_on_rise = 0;
    int   unstable = 0;
    logic valid_q = 1'b0;
    logic [7:0] data_q = 8'h00;
    logic [7:0] got_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records delivered bytes and counts pulse-cycles of each flag.
    always @(negedge clk) begin
        if (valid && !valid_q) begin
            got_q.push_back(data);
            rise_cyc = cyc;
            if (parity_err) pe_on_rise = pe_on_rise + 1;
        end
        if (valid && valid_q && data !== data_q) unstable = unstable + 1;
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
        valid_q = valid;
        data_q  = data;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame LSB first; bad_par inverts the even-parity bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        logic [11:0] bits;
        bits       = '0;
        bits[8:1]  = b;
`ifdef UART_RX_PARITY_EN
        bits[9]    = (^b) ^ bad_par;
`else
        bits[9]    = bad_par;
`endif
        bits[NB-1] = stop_bit;
        for (int i = 0; i < NB; i++) begin
            rx = bits[i];
            if (i == 0) t0 = cyc;
            step(CPB);
        end
    endtask

    task automatic test_reset();
        int fe0;
        reset_n = 1'b0;
        rx      = 1'b0;
        ready   = 1'b0;
        step(3);
        checks++;
        if ({data, valid, frame_err, overrun, parity_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 000", {data, valid, frame_err, overrun, parity_err});
        end
        reset_n = 1'b1;
        fe0 = fe_cnt;
        step(1);
        checks++;
        if ({data, valid, frame_err, overrun, parity_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: got %h expected 000", {data, valid, frame_err, overrun, parity_err});
        end
        step(3);
        rx = 1'b1;
        step(40);
        checks++;
        if (fe_cnt - fe0 != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL reset_quiet: frame_err %0d bytes %0d expected 0 0", fe_cnt - fe0, got_q.size());
        end
    endtask

    task automatic test_single();
        int n0, fe0, ov0, pe0;
        n0 = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        step(4);
        checks++;
        if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'hA5) begin
            errors++;
            $display("FAIL single_data: got %0d bytes last %h expected 1 byte a5", got_q.size() - n0, got_q[got_q.size()-1]);
        end
        checks++;
        if (rise_cyc - t0 != LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d expected %0d", rise_cyc - t0, LAT);
        end
        checks++;
        if (fe_cnt != fe0 || ov_cnt != ov0 || pe_cnt != pe0) begin
            errors++;
            $display("FAIL single_flags: fe %0d ov %0d pe %0d expected 0 0 0", fe_cnt - fe0, ov_cnt - ov0, pe_cnt - pe0);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consumed: valid %b expected 0", valid);
        end
    endtask

    task automatic test_back_to_back();
        int n0, ov0;
        n0 = got_q.size(); ov0 = ov_cnt;
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        step(4);
        checks++;
        if (valid !== 1'b1 || data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_hold: valid %b data %h expected 1 3c", valid, data);
        end
        checks++;
        if (ov_cnt - ov0 != 1 || got_q.size() != n0 + 1) begin
            errors++;
            $display("FAIL b2b_overrun: overrun %0d rises %0d expected 1 1", ov_cnt - ov0, got_q.size() - n0);
        end
        ready = 1'b1;
        step(1);
        checks++;
        if (valid !== 1'b0 || data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_release: valid %b data %h expected 0 3c", valid, data);
        end
    endtask

    task automatic test_glitch();
        int n0, fe0;
        n0 = got_q.size(); fe0 = fe_cnt;
        rx = 1'b0;
        step(5);
        rx = 1'b1;
        step(30);
        checks++;
        if (got_q.size() != n0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL glitch_ignored: bytes %0d frame_err %0d expected 0 0", got_q.size() - n0, fe_cnt - fe0);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        step(4);
        checks++;
        if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'h5A) begin
            errors++;
            $display("FAIL glitch_recover: got %0d bytes last %h expected 1 5a", got_q.size() - n0, got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_break();
        int n0, fe0;
        n0 = got_q.size(); fe0 = fe_cnt;
        send_frame(8'h99, 1'b0, 1'b0);
        step(100);
        rx = 1'b1;
        step(20);
        checks++;
        if (fe_cnt - fe0 != 1 || got_q.size() != n0) begin
            errors++;
            $display("FAIL break_one_err: frame_err %0d bytes %0d expected 1 0", fe_cnt - fe0, got_q.size() - n0);
        end
        send_frame(8'h55, 1'b1, 1'b0);
        step(4);
        checks++;
        if (got_q.size() != n0 + 1 || got_q[got_q.size()-1] !== 8'h55 || fe_cnt - fe0 != 1) begin
            errors++;
            $display("FAIL break_recover: bytes %0d last %h fe %0d expected 1 55 1", got_q.size() - n0, got_q[got_q.size()-1], fe_cnt - fe0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int n0, pe0, pr0;
        n0 = got_q.size(); pe0 = pe_cnt; pr0 = pe_on_rise;
        send_frame(8'h07, 1'b1, 1'b0);
        step(4);
        checks++;
        if (got_q[got_q.size()-1] !== 8'h07 || pe_cnt != pe0) begin
            errors++;
            $display("FAIL parity_good: data %h pe %0d expected 07 0", got_q[got_q.size()-1], pe_cnt - pe0);
        end
        send_frame(8'h07, 1'b1, 1'b1);
        step(4);
        checks++;
        if (got_q.size() != n0 + 2 || got_q[got_q.size()-1] !== 8'h07 || pe_cnt - pe0 != 1 || pe_on_rise - pr0 != 1) begin
            errors++;
            $display("FAIL parity_bad: bytes %0d data %h pe %0d on_rise %0d expected 2 07 1 1",
                     got_q.size() - n0, got_q[got_q.size()-1], pe_cnt - pe0, pe_on_rise - pr0);
        end
    endtask
`endif

    // Random bytes and idle gaps (gap 0 = back-to-back) against an expected-byte queue.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       bad;
        int         n0, pe0, exp_pe;
        n0 = got_q.size(); pe0 = pe_cnt; exp_pe = 0;
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b   = 8'($urandom);
`ifdef UART_RX_PARITY_EN
            bad = 1'($urandom_range(0, 1));
`else
            bad = 1'b0;
`endif
            if (bad) exp_pe++;
            exp_q.push_back(b);
            send_frame(b, 1'b1, bad);
            rx = 1'b1;
            step($urandom_range(0, 12));
        end
        step(4);
        checks++;
        if (got_q.size() - n0 != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d expected %0d", got_q.size() - n0, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && n0 + k < got_q.size(); k++) begin
            checks++;
            if (got_q[n0 + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL random_byte%0d: got %h expected %h", k, got_q[n0 + k], exp_q[k]);
            end
        end
        checks++;
        if (pe_cnt - pe0 != exp_pe) begin
            errors++;
            $display("FAIL random_parity: got %0d expected %0d", pe_cnt - pe0, exp_pe);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL data_stable: changes while valid %0d expected 0", unstable);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
